bus_uart_rx: RTL
================

# bus_uart_rx

Bus-mapped UART receive peripheral: the CPU-readable counterpart of the write-only terminal/GPIO output path. It deserializes 8N1 frames from a serial line, buffers received bytes in a small FIFO, and presents data and status registers on the data read bus behind a read-side address decoder (`busdev`). Reads are single-cycle-enable, byte-wide, and zero-extended by the read mux.

## Interface
- `PREDIV`, default 520: clock cycles per bit (9600 bps at 5 MHz).
- `PREMID`, default 250: cycles from the detected start edge to the start-bit mid-sample; must satisfy 0 < `PREMID` < `PREDIV`.
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `clk` in 1: CPU clock. One clock; reset is asynchronous and active-high.
- `rst` in 1: async active-high reset.
- `en` in 1: read-select from the decoder, i.e. `deven`.
- `addr` in 4: device-relative address; only `addr[3:2]` is decoded.
- `rdata` out 8: registered read data.
- `phyrx` in 1: serial input, idle high.
- `avail` out 1: FIFO non-empty, for polling or interrupt.

## Operation
- Register map, selected by `addr[3:2]`:
  - 0 = DATA: returns the FIFO head and pops it.
  - 1 = STATUS: {4'b0, ferr, ovr, full, avail}. Reading it clears `ovr` and `ferr`.
  - 2 = COUNT: zero-extended occupancy.
  - 3 = reads 0x00.
- An access is the rising edge of `en` (`en` & !`en_q`). Holding `en` high produces no further pops or clears. Address is sampled on the access cycle.
- DATA read when empty: returns 0x00, no pop, no flag change.
- `phyrx` passes through a 2-flop synchronizer. All receiver logic uses the synchronized value.
- Receiver FSM:
  - IDLE: on synchronized `phyrx`==0, clear the counter and go to START.
  - START: when counter==`PREMID`, sample the line. If 0, go to DATA with bit index 0 and clear the counter. If 1, the start was false; return to IDLE with no flags.
  - DATA: when counter==`PREDIV`-1, sample into bit[index] (LSB first) and clear the counter. After bit 7, go to STOP.
  - STOP: when counter==`PREDIV`-1, sample. If 1, push the byte. If 0, set `ferr` and discard the byte. Return to IDLE in both cases.
- Push when full: the byte is dropped and `ovr` is set. FIFO contents are unchanged.
- Push and pop in the same cycle:
  - Not full: both take effect and the count is unchanged.
  - Full: the pop is applied first and the push succeeds. `ovr` is not set.
  - Empty: the push happens, and the DATA read returns 0x00.
- A flag-set event coinciding with a STATUS read: the set wins, so the flag stays 1.
- FIFO pointers are log2(`DEPTH`)+1 bits wide and wrap naturally. `full` is defined as count==`DEPTH`.

## Timing
- Reset values:
  - `rdata`=0x00, `avail`=0.
  - FIFO empty, `ovr`=`ferr`=0.
  - FSM in IDLE, synchronizer flops = 1.
- Reset is honoured mid-frame. The partial byte is lost, and the first frame after reset deasserts is received normally.
- Read latency: `rdata` is valid on the clock edge after the access cycle and holds until the next access.
- Start detection: 2 cycles of synchronizer latency after the `phyrx` falling edge.
- Sample points, measured from start-state entry:
  - Start bit: `PREMID`.
  - Data bit i: `PREMID` + (i+1)·`PREDIV`.
  - Stop bit: `PREMID` + 9·`PREDIV`.
- The push occurs on the stop-sample edge. `avail` and COUNT reflect it on the next cycle.
- IDLE is re-entered mid-stop-bit, so back-to-back frames with no idle gap are received.

## Test plan
- Use `PREDIV`=16, `PREMID`=8, `DEPTH`=4 for all scenarios.
- Basic frame: send 0xA5 with stop=1 → `avail`=1, STATUS=0x01, COUNT=1. Then DATA=0xA5, then STATUS=0x00 and `avail`=0.
- Ordering and overrun: send 0x01..0x05 back-to-back → STATUS=0x07 (`ovr`, `full`, `avail`). DATA reads return 0x01–0x04, then 0x00 on empty. A second STATUS read returns 0x00 because `ovr` was cleared.
- Framing error and glitch:
  - Frame 0x3C with stop=0 → no push, STATUS=0x08.
  - 3-cycle low pulse on `phyrx` → no push, no flags.
- Held `en`: hold `en` for 5 cycles on DATA with 2 bytes queued → exactly one pop, COUNT=1.
- Reset mid-frame: assert `rst` during bit 4 → `rdata`=0, `avail`=0. The following frame 0x5A is read back correctly.
- Simultaneous events: with the FIFO full, a DATA read coincides with a stop-bit push → COUNT stays 4, `ovr`=0, and the new byte is last in order.

Source files
------------

// File: rtl/bus_uart_rx.sv
// bus_uart_rx: 8N1 serial receiver with byte FIFO and a read-only register window.
// Ports: clk/rst (async, active-high), en (device read select, acts on its rising edge),
// addr[3:2] (0=DATA pop, 1=STATUS {ferr,ovr,full,avail} clear-on-read, 2=COUNT, 3=zero),
// rdata (registered read data), phyrx (serial line, idle high), avail (FIFO non-empty).
module bus_uart_rx #(
  parameter int PREDIV = 520,
  parameter int PREMID = 250,
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] addr,
  output logic [7:0] rdata,
  input  logic       phyrx,
  output logic       avail
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(PREDIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0] idx, idx_d;
  logic [7:0] sh, sh_d;
  logic s1, rx, push, fe, en_q, ovr, ferr;
  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp, count;
  logic [1:0] sel;
  logic acc, pop, wr, full, empty, clr;
  logic [7:0] status, rd;
  always_comb begin
    state_d = state;
    cnt_d = cnt + CW'(1);
    idx_d = idx;
    sh_d = sh;
    push = 1'b0;
    fe = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        state_d = rx ? IDLE : START;
      end
      START: if (cnt == CW'(PREMID)) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx ? IDLE : DATA;
      end
      DATA: if (cnt == CW'(PREDIV - 1)) begin
        cnt_d = '0;
        sh_d = {rx, sh[7:1]};
        idx_d = idx + 3'd1;
        state_d = (idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt == CW'(PREDIV - 1)) begin
        push = rx;
        fe = !rx;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign count = wp - rp;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign avail = !empty;
  assign sel = addr[3:2];
  assign acc = en && !en_q;
  assign pop = acc && sel == 2'd0 && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign wr = push && (!full || pop);
  assign clr = acc && sel == 2'd1;
  assign status = {4'b0, ferr, ovr, full, avail};
  assign rd = sel == 2'd0 ? (empty ? 8'h00 : mem[rp[AW-1:0]]) :
              sel == 2'd1 ? status :
              sel == 2'd2 ? 8'(count) : 8'h00;
  always_ff @(posedge clk) if (wr) mem[wp[AW-1:0]] <= sh;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      rx <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      en_q <= 1'b0;
      rdata <= '0;
      wp <= '0;
      rp <= '0;
      ovr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      s1 <= phyrx;
      rx <= s1;
      state <= state_d;
      cnt <= cnt_d;
      idx <= idx_d;
      sh <= sh_d;
      en_q <= en;
      rdata <= acc ? rd : rdata;
      wp <= wp + (AW+1)'(wr);
      rp <= rp + (AW+1)'(pop);
      ovr <= (push && full && !pop) || (ovr && !clr);
      ferr <= fe || (ferr && !clr);
    end
  end
endmodule
